// File: rtl/ar_kbd_pkg.sv
// Shared PS/2 set-2 scancode constants and parser types for the Action Replay
// freeze-key decoder.
package ar_kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_REL   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_BREAK = 8'h7E;
  localparam logic [7:0] SC_NUMLK = 8'h77;
  localparam logic [7:0] SC_BAT   = 8'hAA;

  localparam logic [2:0] PAUSE_LAST = 3'd6;

  // Bytes following the leading E1 of the Pause/Break make sequence
  localparam logic [7:0] PAUSE_SEQ [7] = '{
    SC_CTRL, SC_NUMLK, SC_PAUSE, SC_REL, SC_CTRL, SC_REL, SC_NUMLK
  };

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REL     = 3'd1,
    ST_EXT     = 3'd2,
    ST_EXT_REL = 3'd3,
    ST_PAUSE   = 3'd4
  } parser_state_e;

endpackage

// File: rtl/ar_pulse_stretch.sv
// Stretches a one-cycle freeze trigger into a FREEZE_CYCLES-long level;
// triggers arriving while a pulse is active are dropped.
module ar_pulse_stretch #(
  parameter int unsigned FREEZE_CYCLES = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  input  logic enable,
  output logic freeze
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FREEZE_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_freeze;

  // Next counter value: load on an accepted trigger, otherwise count down to zero
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (trigger && enable && (r_cnt == CNT_ZERO)) begin
      w_cnt_nxt = CNT_LOAD;
    end else if (r_cnt != CNT_ZERO) begin
      w_cnt_nxt = r_cnt - CNT_ONE;
    end else begin
      w_cnt_nxt = CNT_ZERO;
    end
  end

  // Counter and freeze level; freeze follows the next count so it rises one cycle after the trigger
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= CNT_ZERO;
      r_freeze <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_freeze <= (w_cnt_nxt != CNT_ZERO);
    end
  end

  assign freeze = r_freeze;

endmodule

// File: rtl/ar_freeze_key.sv
// PS/2 set-2 parser that detects Ctrl+Break (either extended E0 7E or the
// Pause sequence with Ctrl held) and drives a stretched freeze request.
import ar_kbd_pkg::*;

module ar_freeze_key #(
  parameter int unsigned FREEZE_CYCLES = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       kbd_enable,
  output logic       freeze,
  output logic       ctrl_held
);

  parser_state_e r_state;
  parser_state_e w_state_nxt;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_nxt;
  logic          r_lctrl;
  logic          r_rctrl;
  logic          w_lctrl_nxt;
  logic          w_rctrl_nxt;
  logic          r_ctrl_held;
  logic          w_detect;
  logic          w_ctrl_any;

  assign w_ctrl_any = r_lctrl | r_rctrl;

  // Scancode parser: next state, Ctrl tracking and detect strobe
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_lctrl_nxt = r_lctrl;
    w_rctrl_nxt = r_rctrl;
    w_detect    = 1'b0;
    if (scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          case (scan_code)
            SC_EXT:   w_state_nxt = ST_EXT;
            SC_REL:   w_state_nxt = ST_REL;
            SC_PAUSE: begin
              w_state_nxt = ST_PAUSE;
              w_idx_nxt   = 3'd0;
            end
            SC_CTRL:  w_lctrl_nxt = 1'b1;
            SC_BAT: begin
              w_lctrl_nxt = 1'b0;
              w_rctrl_nxt = 1'b0;
            end
            default:  w_state_nxt = ST_IDLE;
          endcase
        end
        ST_REL: begin
          w_state_nxt = ST_IDLE;
          if (scan_code == SC_CTRL) begin
            w_lctrl_nxt = 1'b0;
          end else begin
            w_lctrl_nxt = r_lctrl;
          end
        end
        ST_EXT: begin
          case (scan_code)
            SC_CTRL: begin
              w_rctrl_nxt = 1'b1;
              w_state_nxt = ST_IDLE;
            end
            SC_BREAK: begin
              w_detect    = w_ctrl_any;
              w_state_nxt = ST_IDLE;
            end
            SC_REL:  w_state_nxt = ST_EXT_REL;
            default: w_state_nxt = ST_IDLE;
          endcase
        end
        ST_EXT_REL: begin
          w_state_nxt = ST_IDLE;
          if (scan_code == SC_CTRL) begin
            w_rctrl_nxt = 1'b0;
          end else begin
            w_rctrl_nxt = r_rctrl;
          end
        end
        ST_PAUSE: begin
          // A mismatching byte is swallowed rather than re-parsed from IDLE
          if (scan_code == PAUSE_SEQ[r_idx]) begin
            if (r_idx == PAUSE_LAST) begin
              w_detect    = w_ctrl_any;
              w_state_nxt = ST_IDLE;
              w_idx_nxt   = 3'd0;
            end else begin
              w_idx_nxt = r_idx + 3'd1;
            end
          end else begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 3'd0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = 3'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Parser and Ctrl state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= 3'd0;
      r_lctrl     <= 1'b0;
      r_rctrl     <= 1'b0;
      r_ctrl_held <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_lctrl     <= w_lctrl_nxt;
      r_rctrl     <= w_rctrl_nxt;
      r_ctrl_held <= w_lctrl_nxt | w_rctrl_nxt;
    end
  end

  ar_pulse_stretch #(
    .FREEZE_CYCLES (FREEZE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_stretch (
    .clk     (clk),
    .reset   (reset),
    .trigger (w_detect),
    .enable  (kbd_enable),
    .freeze  (freeze)
  );

  assign ctrl_held = r_ctrl_held;

endmodule

// File: tb/tb_ar_freeze_key.sv
// Directed table-driven bench for ar_freeze_key (FREEZE_CYCLES = 16).
module tb_ar_freeze_key;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       kbd_enable = 1'b1;
  logic       freeze;
  logic       ctrl_held;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       valid;
    logic [7:0] code;
    logic       en;
    int         rep;
    logic       ef;
    logic       ec;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  ar_freeze_key #(.FREEZE_CYCLES(16), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .kbd_enable (kbd_enable),
    .freeze     (freeze),
    .ctrl_held  (ctrl_held)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] c, input logic en,
                     input int rep, input logic ef, input logic ec);
    vec_t t;
    t.valid = v; t.code = c; t.en = en; t.rep = rep; t.ef = ef; t.ec = ec;
    vq.push_back(t);
  endtask

  // one scancode byte, enabled, with expected outputs after its edge
  task automatic b(input logic [7:0] c, input logic ef, input logic ec);
    add(1'b1, c, 1'b1, 1, ef, ec);
  endtask

  task automatic idle(input int n, input logic ef, input logic ec);
    add(1'b0, 8'h00, 1'b1, n, ef, ec);
  endtask

  task automatic drive_byte(input logic [7:0] c);
    scan_valid = 1'b1;
    scan_code  = c;
    @(negedge clk);
    scan_valid = 1'b0;
    scan_code  = 8'h00;
  endtask

  initial begin
    // 1: left Ctrl + E0 7E, 16-cycle pulse
    b(8'h14, 1'b0, 1'b1);
    b(8'hE0, 1'b0, 1'b1);
    b(8'h7E, 1'b1, 1'b1);
    idle(15, 1'b1, 1'b1);
    idle(2, 1'b0, 1'b1);
    b(8'hF0, 1'b0, 1'b1);
    b(8'h14, 1'b0, 1'b0);
    // 2: no Ctrl -> nothing; right Ctrl -> pulse; right Ctrl released -> nothing
    b(8'hE0, 1'b0, 1'b0);
    b(8'h7E, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    b(8'hE0, 1'b0, 1'b0);
    b(8'h14, 1'b0, 1'b1);
    b(8'hE0, 1'b0, 1'b1);
    b(8'h7E, 1'b1, 1'b1);
    idle(15, 1'b1, 1'b1);
    idle(2, 1'b0, 1'b1);
    b(8'hE0, 1'b0, 1'b1);
    b(8'hF0, 1'b0, 1'b1);
    b(8'h14, 1'b0, 1'b0);
    b(8'hE0, 1'b0, 1'b0);
    b(8'h7E, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);
    // 3: Pause sequence with left Ctrl held; inner F0 14 must not release Ctrl
    b(8'h14, 1'b0, 1'b1);
    b(8'hE1, 1'b0, 1'b1);
    b(8'h14, 1'b0, 1'b1);
    b(8'h77, 1'b0, 1'b1);
    b(8'hE1, 1'b0, 1'b1);
    b(8'hF0, 1'b0, 1'b1);
    b(8'h14, 1'b0, 1'b1);
    b(8'hF0, 1'b0, 1'b1);
    b(8'h77, 1'b1, 1'b1);
    idle(15, 1'b1, 1'b1);
    idle(2, 1'b0, 1'b1);
    // corrupted 5th byte: 15 swallowed, rest parsed from IDLE, no pulse
    b(8'hE1, 1'b0, 1'b1);
    b(8'h14, 1'b0, 1'b1);
    b(8'h77, 1'b0, 1'b1);
    b(8'hE1, 1'b0, 1'b1);
    b(8'h15, 1'b0, 1'b1);
    b(8'h14, 1'b0, 1'b1);
    b(8'hF0, 1'b0, 1'b1);
    b(8'h77, 1'b0, 1'b1);
    idle(3, 1'b0, 1'b1);
    // 4: parser back in IDLE; retrigger during pulse is dropped
    b(8'hE0, 1'b0, 1'b1);
    b(8'h7E, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    b(8'hE0, 1'b1, 1'b1);
    b(8'h7E, 1'b1, 1'b1);
    idle(10, 1'b1, 1'b1);
    idle(2, 1'b0, 1'b1);
    b(8'hE0, 1'b0, 1'b1);
    b(8'h7E, 1'b1, 1'b1);
    idle(15, 1'b1, 1'b1);
    idle(1, 1'b0, 1'b1);
    // 5: detection suppressed when disabled, Ctrl still tracked; BAT clears Ctrl
    add(1'b1, 8'hE0, 1'b0, 1, 1'b0, 1'b1);
    add(1'b1, 8'h7E, 1'b0, 1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 3, 1'b0, 1'b1);
    b(8'hAA, 1'b0, 1'b0);
    b(8'hE0, 1'b0, 1'b0);
    b(8'h7E, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("reset_freeze", freeze, 1'b0);
    chk("reset_ctrl", ctrl_held, 1'b0);
    reset = 1'b0;

    foreach (vq[i]) begin
      for (int r = 0; r < vq[i].rep; r++) begin
        scan_valid = vq[i].valid;
        scan_code  = vq[i].code;
        kbd_enable = vq[i].en;
        @(negedge clk);
        chk($sformatf("vec%0d.%0d freeze", i, r), freeze, vq[i].ef);
        chk($sformatf("vec%0d.%0d ctrl_held", i, r), ctrl_held, vq[i].ec);
      end
    end
    scan_valid = 1'b0;
    kbd_enable = 1'b1;

    // 6: asynchronous reset five cycles into a pulse
    drive_byte(8'h14);
    drive_byte(8'hE0);
    drive_byte(8'h7E);
    chk("pre_rst_freeze", freeze, 1'b1);
    repeat (4) @(negedge clk);
    chk("pre_rst_hold", freeze, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_freeze", freeze, 1'b0);
    chk("async_rst_ctrl", ctrl_held, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive_byte(8'hE0);
    drive_byte(8'h7E);
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("post_rst%0d freeze", k), freeze, 1'b0);
      chk($sformatf("post_rst%0d ctrl", k), ctrl_held, 1'b0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
